// File: rtl/issue_ctrl_pkg.sv
// Shared encodings for the issue stage: instruction classes, sequencer
// states, ROB tag range and stall-cause codes.
package issue_ctrl_pkg;

  // Instruction class as delivered by decode; SYS needs no RS entry
  typedef enum logic [1:0] {
    CLASS_ALU = 2'd0,
    CLASS_MEM = 2'd1,
    CLASS_BR  = 2'd2,
    CLASS_SYS = 2'd3
  } inst_class_e;

  // Issue sequencer states
  typedef enum logic [0:0] {
    ISSUE_RUN     = 1'b0,
    ISSUE_RECOVER = 1'b1
  } issue_state_t;

  // Tag 0 means "value ready" in the register status table, so live
  // ROB tags run 1..15 and the ROB holds 15 entries.
  localparam logic [3:0] ROB_FIRST_TAG = 4'd1;
  localparam logic [3:0] ROB_LAST_TAG  = 4'd15;
  localparam logic [3:0] ROB_CAPACITY  = 4'd15;

  // Number of reservation-station banks (ALU, MEM, BR)
  localparam int NUM_RS = 3;

  // Reason the offered instruction was not accepted
  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_ROB_FULL = 2'd1;
  localparam logic [1:0] STALL_RS_FULL  = 2'd2;
  localparam logic [1:0] STALL_FLUSH    = 2'd3;

  // Successor of a ROB tag, skipping the reserved tag 0
  function automatic logic [3:0] rob_next_tag(input logic [3:0] tag);
    return (tag == ROB_LAST_TAG) ? ROB_FIRST_TAG : tag + 4'd1;
  endfunction

endpackage

// File: rtl/issue_ctrl_rob_tag_ptr.sv
// ROB tag pointer: advances 1..15 and wraps back to 1, never touching the
// reserved tag 0. Clear has priority over advance.
module rob_tag_ptr
  import issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic [3:0] tag_o
);

  logic [3:0] tag_q;
  logic [3:0] tag_d;

  // Next pointer: clear to the first tag, otherwise step on advance
  always_comb begin
    tag_d = tag_q;
    if (clr_i) begin
      tag_d = ROB_FIRST_TAG;
    end else if (adv_i) begin
      tag_d = rob_next_tag(tag_q);
    end
  end

  // Pointer register, reset to the first live tag
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= ROB_FIRST_TAG;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage sequencer: decides issue each cycle, hands out ROB tags,
// strobes the matching RS bank, drives the regstat issue port, tracks ROB
// occupancy from commits and holds issue off for a window after a flush.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       inst_valid,
  input  logic [1:0] inst_class,
  input  logic       inst_writes,
  input  logic [4:0] inst_rd,
  input  logic [2:0] rs_free,
  input  logic       commit_valid,
  output logic       inst_ready,
  output logic [2:0] rs_alloc,
  output logic       rob_alloc,
  output logic       issue_writes,
  output logic [4:0] issue_dest,
  output logic [3:0] issue_ROB,
  output logic [3:0] rob_head,
  output logic [3:0] rob_count,
  output logic [1:0] stall_cause
);

  localparam logic [0:0] ST_RUN     = ISSUE_RUN;
  localparam logic [0:0] ST_RECOVER = ISSUE_RECOVER;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [2:0] recover_cnt_q;
  logic [2:0] recover_cnt_d;
  logic [3:0] count_q;
  logic [3:0] count_d;

  logic [3:0] head_tag;
  logic [3:0] tail_tag;

  logic       rob_full;
  logic       rs_room;
  logic       is_sys;
  logic       accept;
  logic       commit_eff;
  logic       flushing;
  logic [2:0] rs_match;

  // Per-bank class decode: room check and one-hot allocate strobe
  generate
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
      assign rs_match[gi] = rs_free[gi] & (inst_class == 2'(gi));
      assign rs_alloc[gi] = accept & (inst_class == 2'(gi));
    end
  endgenerate

  assign is_sys   = (inst_class == CLASS_SYS);
  assign rs_room  = is_sys | (|rs_match);
  // Full check uses the registered count, so a same-cycle commit does not
  // open a slot for this cycle's instruction.
  assign rob_full = (count_q == ROB_CAPACITY);
  assign flushing = flush | (state_q == ST_RECOVER);

  assign accept = ~reset & (state_q == ST_RUN) & inst_valid & ~flush &
                  ~rob_full & rs_room;

  // Commits against an empty ROB are dropped
  assign commit_eff = ~reset & ~flush & commit_valid & (count_q != 4'd0);

  // Head and tail pointers; a flush resets both to the first tag
  rob_tag_ptr u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .adv_i (commit_eff),
    .tag_o (head_tag)
  );

  rob_tag_ptr u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .adv_i (accept),
    .tag_o (tail_tag)
  );

  // Occupancy: flush empties; simultaneous issue and commit cancel out
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 4'd0;
    end else if (accept && !commit_eff) begin
      count_d = count_q + 4'd1;
    end else if (!accept && commit_eff) begin
      count_d = count_q - 4'd1;
    end
  end

  // Recovery sequencing: flush (re)loads the window, RECOVER counts it out
  always_comb begin
    state_d       = state_q;
    recover_cnt_d = recover_cnt_q;
    if (flush) begin
      state_d       = ST_RECOVER;
      recover_cnt_d = FLUSH_LOAD;
    end else if (state_q == ST_RECOVER) begin
      if (recover_cnt_q == 3'd0) begin
        state_d = ST_RUN;
      end else begin
        recover_cnt_d = recover_cnt_q - 3'd1;
      end
    end
  end

  // State, recovery counter and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      recover_cnt_q <= 3'd0;
      count_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      recover_cnt_q <= recover_cnt_d;
      count_q       <= count_d;
    end
  end

  // Stall reason, only meaningful when an instruction is being refused
  always_comb begin
    stall_cause = STALL_NONE;
    if (!reset && inst_valid && !accept) begin
      if (flushing) begin
        stall_cause = STALL_FLUSH;
      end else if (rob_full) begin
        stall_cause = STALL_ROB_FULL;
      end else if (!rs_room) begin
        stall_cause = STALL_RS_FULL;
      end
    end
  end

  assign inst_ready   = accept;
  assign rob_alloc    = accept;
  assign issue_writes = accept & inst_writes & (inst_rd != 5'd0);
  assign issue_dest   = inst_rd;
  assign issue_ROB    = reset ? ROB_FIRST_TAG : tail_tag;
  assign rob_head     = reset ? ROB_FIRST_TAG : head_tag;
  assign rob_count    = reset ? 4'd0 : count_q;

  // Flag commits that arrive while the ROB is empty
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(commit_valid && count_q == 4'd0))
        else $warning("issue_ctrl: commit with empty ROB ignored");
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: one task per scenario, inline checks.
module tb_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       inst_valid;
  logic [1:0] inst_class;
  logic       inst_writes;
  logic [4:0] inst_rd;
  logic [2:0] rs_free;
  logic       commit_valid;
  logic       inst_ready;
  logic [2:0] rs_alloc;
  logic       rob_alloc;
  logic       issue_writes;
  logic [4:0] issue_dest;
  logic [3:0] issue_ROB;
  logic [3:0] rob_head;
  logic [3:0] rob_count;
  logic [1:0] stall_cause;

  int tests = 0;
  int fails = 0;

  issue_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst_class   (inst_class),
    .inst_writes  (inst_writes),
    .inst_rd      (inst_rd),
    .rs_free      (rs_free),
    .commit_valid (commit_valid),
    .inst_ready   (inst_ready),
    .rs_alloc     (rs_alloc),
    .rob_alloc    (rob_alloc),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .issue_ROB    (issue_ROB),
    .rob_head     (rob_head),
    .rob_count    (rob_count),
    .stall_cause  (stall_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs just after the falling edge, settle 2 units
  task automatic drive(input logic v, input logic [1:0] c, input logic w,
                       input logic [4:0] rd, input logic [2:0] rf,
                       input logic cm, input logic fl);
    @(negedge clk);
    inst_valid = v; inst_class = c; inst_writes = w; inst_rd = rd;
    rs_free = rf; commit_valid = cm; flush = fl;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_valid = 0; inst_class = 0; inst_writes = 0; inst_rd = 0;
    rs_free = 0; commit_valid = 0; flush = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_valid = 1; inst_class = 0; inst_writes = 1; inst_rd = 5'd3;
    rs_free = 3'b111; commit_valid = 1; flush = 0;
    @(negedge clk);
    #2;
    tests++; if (inst_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b exp 0", inst_ready); end
    tests++; if (rs_alloc !== 3'b000) begin fails++; $display("FAIL reset_rs_alloc got %b exp 000", rs_alloc); end
    tests++; if (rob_alloc !== 1'b0) begin fails++; $display("FAIL reset_rob_alloc got %0b exp 0", rob_alloc); end
    tests++; if (stall_cause !== 2'd0) begin fails++; $display("FAIL reset_stall got %0d exp 0", stall_cause); end
    tests++; if (issue_ROB !== 4'd1) begin fails++; $display("FAIL reset_issue_rob got %0d exp 1", issue_ROB); end
    tests++; if (rob_head !== 4'd1) begin fails++; $display("FAIL reset_head got %0d exp 1", rob_head); end
    tests++; if (rob_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", rob_count); end
    commit_valid = 0; inst_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    tests++; if (rob_count !== 4'd0 || rob_head !== 4'd1 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL post_reset_ptrs got cnt=%0d head=%0d tail=%0d exp 0/1/1", rob_count, rob_head, issue_ROB); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_issue();
    do_reset();
    drive(1, 2'd0, 1, 5'd5, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %0b exp 1", inst_ready); end
    tests++; if (rs_alloc !== 3'b001) begin fails++; $display("FAIL basic_rs_alloc got %b exp 001", rs_alloc); end
    tests++; if (issue_ROB !== 4'd1) begin fails++; $display("FAIL basic_issue_rob got %0d exp 1", issue_ROB); end
    tests++; if (issue_writes !== 1'b1) begin fails++; $display("FAIL basic_writes got %0b exp 1", issue_writes); end
    tests++; if (issue_dest !== 5'd5) begin fails++; $display("FAIL basic_dest got %0d exp 5", issue_dest); end
    tests++; if (rob_alloc !== 1'b1) begin fails++; $display("FAIL basic_rob_alloc got %0b exp 1", rob_alloc); end
    drive(0, 2'd0, 1, 5'd9, 3'b111, 0, 0);
    tests++; if (issue_ROB !== 4'd2) begin fails++; $display("FAIL basic_next_rob got %0d exp 2", issue_ROB); end
    tests++; if (rob_count !== 4'd1) begin fails++; $display("FAIL basic_count got %0d exp 1", rob_count); end
    tests++; if (inst_ready !== 1'b0 || issue_writes !== 1'b0) begin fails++;
      $display("FAIL basic_idle_strobes got ready=%0b wr=%0b exp 0/0", inst_ready, issue_writes); end
    tests++; if (issue_dest !== 5'd9) begin fails++; $display("FAIL basic_idle_dest got %0d exp 9", issue_dest); end
    drive(0, 2'd0, 0, 5'd0, 3'b111, 1, 0);
    drive(0, 2'd0, 0, 5'd0, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd0 || rob_head !== 4'd2) begin fails++;
      $display("FAIL basic_commit got cnt=%0d head=%0d exp 0/2", rob_count, rob_head); end
    $display("[TB] test_basic_issue done");
  endtask

  task automatic test_rob_full();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      drive(1, 2'd0, 1, 5'(i), 3'b111, 0, 0);
      tests++; if (inst_ready !== 1'b1 || issue_ROB !== 4'(i)) begin fails++;
        $display("FAIL full_fill_%0d got ready=%0b tag=%0d exp 1/%0d", i, inst_ready, issue_ROB, i); end
    end
    drive(1, 2'd0, 1, 5'd3, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd15) begin fails++; $display("FAIL full_count got %0d exp 15", rob_count); end
    tests++; if (inst_ready !== 1'b0 || rob_alloc !== 1'b0) begin fails++;
      $display("FAIL full_ready got ready=%0b alloc=%0b exp 0/0", inst_ready, rob_alloc); end
    tests++; if (stall_cause !== 2'd1) begin fails++; $display("FAIL full_stall got %0d exp 1", stall_cause); end
    drive(1, 2'd0, 1, 5'd3, 3'b000, 0, 0);
    tests++; if (stall_cause !== 2'd1) begin fails++; $display("FAIL full_over_rs_stall got %0d exp 1", stall_cause); end
    drive(1, 2'd0, 1, 5'd3, 3'b111, 1, 0);
    tests++; if (inst_ready !== 1'b0 || stall_cause !== 2'd1) begin fails++;
      $display("FAIL full_commit_same_cycle got ready=%0b stall=%0d exp 0/1", inst_ready, stall_cause); end
    drive(1, 2'd0, 1, 5'd3, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd14 || rob_head !== 4'd2) begin fails++;
      $display("FAIL full_after_commit got cnt=%0d head=%0d exp 14/2", rob_count, rob_head); end
    tests++; if (inst_ready !== 1'b1 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL full_wrap_issue got ready=%0b tag=%0d exp 1/1", inst_ready, issue_ROB); end
    drive(0, 2'd0, 0, 5'd0, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd15 || issue_ROB !== 4'd2) begin fails++;
      $display("FAIL full_wrap_after got cnt=%0d tag=%0d exp 15/2", rob_count, issue_ROB); end
    $display("[TB] test_rob_full done");
  endtask

  task automatic test_rs_full();
    do_reset();
    drive(1, 2'd1, 1, 5'd4, 3'b101, 0, 0);
    tests++; if (inst_ready !== 1'b0 || stall_cause !== 2'd2) begin fails++;
      $display("FAIL rs_mem_block got ready=%0b stall=%0d exp 0/2", inst_ready, stall_cause); end
    tests++; if (rs_alloc !== 3'b000 || rob_alloc !== 1'b0) begin fails++;
      $display("FAIL rs_mem_block_strobes got rs=%b rob=%0b exp 000/0", rs_alloc, rob_alloc); end
    drive(1, 2'd1, 1, 5'd4, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b1 || rs_alloc !== 3'b010 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL rs_mem_go got ready=%0b rs=%b tag=%0d exp 1/010/1", inst_ready, rs_alloc, issue_ROB); end
    drive(1, 2'd2, 0, 5'd4, 3'b011, 0, 0);
    tests++; if (inst_ready !== 1'b0 || stall_cause !== 2'd2) begin fails++;
      $display("FAIL rs_br_block got ready=%0b stall=%0d exp 0/2", inst_ready, stall_cause); end
    drive(1, 2'd2, 0, 5'd4, 3'b100, 0, 0);
    tests++; if (inst_ready !== 1'b1 || rs_alloc !== 3'b100 || issue_writes !== 1'b0 || issue_ROB !== 4'd2) begin fails++;
      $display("FAIL rs_br_go got ready=%0b rs=%b wr=%0b tag=%0d exp 1/100/0/2", inst_ready, rs_alloc, issue_writes, issue_ROB); end
    $display("[TB] test_rs_full done");
  endtask

  task automatic test_sys();
    do_reset();
    drive(1, 2'd3, 1, 5'd0, 3'b000, 0, 0);
    tests++; if (inst_ready !== 1'b1 || rob_alloc !== 1'b1) begin fails++;
      $display("FAIL sys_accept got ready=%0b rob=%0b exp 1/1", inst_ready, rob_alloc); end
    tests++; if (rs_alloc !== 3'b000 || issue_writes !== 1'b0 || stall_cause !== 2'd0) begin fails++;
      $display("FAIL sys_strobes got rs=%b wr=%0b stall=%0d exp 000/0/0", rs_alloc, issue_writes, stall_cause); end
    drive(1, 2'd0, 1, 5'd0, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b1 || issue_writes !== 1'b0 || issue_ROB !== 4'd2) begin fails++;
      $display("FAIL alu_rd0 got ready=%0b wr=%0b tag=%0d exp 1/0/2", inst_ready, issue_writes, issue_ROB); end
    $display("[TB] test_sys done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 2'd0, 1, 5'd1, 3'b111, 0, 0);
    drive(1, 2'd0, 1, 5'd7, 3'b111, 1, 0);
    tests++; if (inst_ready !== 1'b1 || issue_ROB !== 4'd4 || rob_count !== 4'd3) begin fails++;
      $display("FAIL b2b_issue got ready=%0b tag=%0d cnt=%0d exp 1/4/3", inst_ready, issue_ROB, rob_count); end
    drive(0, 2'd0, 0, 5'd0, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd3 || rob_head !== 4'd2 || issue_ROB !== 4'd5) begin fails++;
      $display("FAIL b2b_after got cnt=%0d head=%0d tag=%0d exp 3/2/5", rob_count, rob_head, issue_ROB); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    drive(1, 2'd0, 1, 5'd2, 3'b111, 1, 1);
    tests++; if (rob_count !== 4'd6) begin fails++; $display("FAIL flush_pre_count got %0d exp 6", rob_count); end
    tests++; if (inst_ready !== 1'b0 || rob_alloc !== 1'b0 || rs_alloc !== 3'b000 || stall_cause !== 2'd3) begin fails++;
      $display("FAIL flush_cycle got ready=%0b rob=%0b rs=%b stall=%0d exp 0/0/000/3", inst_ready, rob_alloc, rs_alloc, stall_cause); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd0 || rob_head !== 4'd1 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL flush_ptrs got cnt=%0d head=%0d tag=%0d exp 0/1/1", rob_count, rob_head, issue_ROB); end
    tests++; if (inst_ready !== 1'b0 || stall_cause !== 2'd3) begin fails++;
      $display("FAIL flush_rec1 got ready=%0b stall=%0d exp 0/3", inst_ready, stall_cause); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b0 || stall_cause !== 2'd3) begin fails++;
      $display("FAIL flush_rec2 got ready=%0b stall=%0d exp 0/3", inst_ready, stall_cause); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b1 || issue_ROB !== 4'd1 || stall_cause !== 2'd0) begin fails++;
      $display("FAIL flush_resume got ready=%0b tag=%0d stall=%0d exp 1/1/0", inst_ready, issue_ROB, stall_cause); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_flush_reload();
    do_reset();
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 1);
    drive(0, 2'd0, 1, 5'd2, 3'b111, 0, 1);
    tests++; if (stall_cause !== 2'd0) begin fails++; $display("FAIL reload_novalid_stall got %0d exp 0", stall_cause); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b0) begin fails++; $display("FAIL reload_blk1 got %0b exp 0", inst_ready); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b0) begin fails++; $display("FAIL reload_blk2 got %0b exp 0", inst_ready); end
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 0);
    tests++; if (inst_ready !== 1'b1) begin fails++; $display("FAIL reload_resume got %0b exp 1", inst_ready); end
    $display("[TB] test_flush_reload done");
  endtask

  task automatic test_reset_recover();
    do_reset();
    drive(1, 2'd0, 1, 5'd2, 3'b111, 0, 1);
    @(negedge clk);
    reset = 1'b1; flush = 0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    tests++; if (inst_ready !== 1'b1 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL reset_recover got ready=%0b tag=%0d exp 1/1", inst_ready, issue_ROB); end
    $display("[TB] test_reset_recover done");
  endtask

  task automatic test_commit_empty();
    do_reset();
    drive(0, 2'd0, 0, 5'd0, 3'b111, 1, 0);
    tests++; if (rob_count !== 4'd0) begin fails++; $display("FAIL empty_commit_now got %0d exp 0", rob_count); end
    drive(0, 2'd0, 0, 5'd0, 3'b111, 0, 0);
    tests++; if (rob_count !== 4'd0 || rob_head !== 4'd1 || issue_ROB !== 4'd1) begin fails++;
      $display("FAIL empty_commit_after got cnt=%0d head=%0d tag=%0d exp 0/1/1", rob_count, rob_head, issue_ROB); end
    $display("[TB] test_commit_empty done");
  endtask

  initial begin
    reset = 1; flush = 0; inst_valid = 0; inst_class = 0; inst_writes = 0;
    inst_rd = 0; rs_free = 0; commit_valid = 0;
    test_reset();
    test_basic_issue();
    test_rob_full();
    test_rs_full();
    test_sys();
    test_back_to_back();
    test_flush();
    test_flush_reload();
    test_reset_recover();
    test_commit_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
